// File: rtl/ram_responder.sv
// RAM-side responder for the memory_control ram* bus: decodes requests, waits LAT
// cycles in BUSY, performs the access in ACCESS and flags malformed requests as ERROR.
module ram_responder #(
    parameter int LAT    = 2,
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
    } req_t;

    localparam logic [3:0] LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        lat_q, lat_nxt, live;
    logic        req, illegal;
    logic [ADDR_W-1:0] idx;
    logic [31:0] mem [2**ADDR_W];

    assign live    = '{ren: ramREN, wen: ramWEN, addr: ramaddr};
    assign req     = ramREN | ramWEN;
    assign illegal = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                     ((ramaddr >> (ADDR_W + 2)) != 32'd0);
    assign idx     = lat_q.addr[ADDR_W+1:2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat_q;
        case (state)
            FREE: begin
                if (req) begin
                    if (illegal) begin
                        state_nxt = ERROR;
                    end else begin
                        lat_nxt   = live;
                        state_nxt = (LAT == 0) ? ACCESS : BUSY;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nxt = FREE;
                end else if (live != lat_q) begin
                    // Retarget/abort: restart the full wait on the new tuple.
                    if (illegal) begin
                        state_nxt = ERROR;
                    end else begin
                        lat_nxt   = live;
                        state_nxt = (LAT == 0) ? ACCESS : BUSY;
                        cnt_nxt   = LAT_M1;
                    end
                end else if (cnt == 4'd0) begin
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACCESS:  state_nxt = FREE;
            default: state_nxt = req ? ERROR : FREE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FREE;
            cnt   <= 4'd0;
            lat_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat_q <= lat_nxt;
        end
    end

    // Commit only if the master still presents the same write when ACCESS ends.
    always_ff @(posedge CLK) begin
        if (!RST && state == ACCESS && lat_q.wen && live == lat_q)
            mem[idx] <= ramstore;
    end

    assign ramstate = state;
    assign ramload  = (state == ACCESS && lat_q.ren) ? mem[idx] : 32'd0;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances with LAT=2, LAT=0 and LAT=3.
module tb_ram_responder;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ren   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] store [3];
    logic [31:0] ld    [3];
    logic [1:0]  st    [3];
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    ram_responder #(.LAT(2), .ADDR_W(10)) u_l2 (
        .CLK(CLK), .RST(RST), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
        .ramstore(store[0]), .ramload(ld[0]), .ramstate(st[0]));
    ram_responder #(.LAT(0), .ADDR_W(10)) u_l0 (
        .CLK(CLK), .RST(RST), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
        .ramstore(store[1]), .ramload(ld[1]), .ramstate(st[1]));
    ram_responder #(.LAT(3), .ADDR_W(10)) u_l3 (
        .CLK(CLK), .RST(RST), .ramREN(ren[2]), .ramWEN(wen[2]), .ramaddr(addr[2]),
        .ramstore(store[2]), .ramload(ld[2]), .ramstate(st[2]));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chks(input int i, input string tag, input logic [1:0] s, input logic [31:0] l);
        chk({tag, " state"}, {30'd0, st[i]}, {30'd0, s});
        chk({tag, " load"}, ld[i], l);
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        ren[i] = r; wen[i] = w; addr[i] = a; store[i] = d;
    endtask

    // Full transaction held until the FREE turnaround, then released.
    task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] exp,
                          input string tag);
        drive(i, r, w, a, d);
        for (int c = 0; c < lat; c++) begin
            tick();
            chks(i, {tag, " busy"}, BUSY, 32'd0);
        end
        tick();
        chks(i, {tag, " access"}, ACCESS, exp);
        tick();
        chks(i, {tag, " free"}, FREE, 32'd0);
        drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'd0);  // request during reset must not latch
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) chks(i, "reset", FREE, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chks(0, "post-reset idle", FREE, 32'd0);

        // LAT=2 write then read
        access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 2, 32'd0, "l2 wr40");
        access(0, 1'b1, 1'b0, 32'h40, 32'd0, 2, 32'hDEADBEEF, "l2 rd40");

        // LAT=0
        access(1, 1'b0, 1'b1, 32'h30, 32'h12345678, 0, 32'd0, "l0 wr30");
        access(1, 1'b1, 1'b0, 32'h30, 32'd0, 0, 32'h12345678, "l0 rd30");

        // LAT=3 retarget after two BUSY cycles
        access(2, 1'b0, 1'b1, 32'h10, 32'h44444444, 3, 32'd0, "l3 wr10");
        access(2, 1'b0, 1'b1, 32'h14, 32'h55555555, 3, 32'd0, "l3 wr14");
        drive(2, 1'b1, 1'b0, 32'h10, 32'd0);
        tick(); chks(2, "rt busy1", BUSY, 32'd0);
        tick(); chks(2, "rt busy2", BUSY, 32'd0);
        addr[2] = 32'h14;
        tick(); chks(2, "rt restart1", BUSY, 32'd0);
        tick(); chks(2, "rt restart2", BUSY, 32'd0);
        tick(); chks(2, "rt restart3", BUSY, 32'd0);
        tick(); chks(2, "rt access", ACCESS, 32'h55555555);
        tick(); chks(2, "rt free", FREE, 32'd0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);

        // Illegal: REN&WEN, held with a legal tuple while in ERROR
        drive(0, 1'b1, 1'b1, 32'h40, 32'h0BAD0BAD);
        tick(); chks(0, "ill both", ERROR, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
        tick(); chks(0, "ill hold legal", ERROR, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); chks(0, "ill both free", FREE, 32'd0);
        // Misaligned write whose word index aliases 0x40
        drive(0, 1'b0, 1'b1, 32'h41, 32'h0BAD0BAD);
        tick(); chks(0, "ill misalign", ERROR, 32'd0);
        tick(); chks(0, "ill misalign hold", ERROR, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); chks(0, "ill misalign free", FREE, 32'd0);
        // Out of range
        drive(0, 1'b0, 1'b1, 32'h1000, 32'h0BAD0BAD);
        tick(); chks(0, "ill range", ERROR, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); chks(0, "ill range free", FREE, 32'd0);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0, 2, 32'hDEADBEEF, "ill mem kept");

        // Write aborted during ACCESS
        access(0, 1'b0, 1'b1, 32'h20, 32'h11112222, 2, 32'd0, "ab pre");
        drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555);
        tick(); chks(0, "ab busy1", BUSY, 32'd0);
        tick(); chks(0, "ab busy2", BUSY, 32'd0);
        tick(); chks(0, "ab access", ACCESS, 32'd0);
        addr[0] = 32'h24;
        tick(); chks(0, "ab free", FREE, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, 2, 32'h11112222, "ab mem kept");

        // Reset during BUSY of a write
        access(0, 1'b0, 1'b1, 32'h8, 32'hCAFE0002, 2, 32'd0, "rs pre");
        drive(0, 1'b0, 1'b1, 32'h8, 32'h1);
        tick(); chks(0, "rs busy", BUSY, 32'd0);
        RST = 1'b1;
        tick(); chks(0, "rs reset", FREE, 32'd0);
        RST = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); chks(0, "rs idle", FREE, 32'd0);
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, 2, 32'hCAFE0002, "rs mem kept");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
